// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache_arbiter slice: FSM states, requester ids, width defaults.
// The ARB_ROUND_ROBIN_EN macro (used by the FSM) selects round-robin tie breaking.
package arbiter_types;

  localparam int unsigned ADDR_WIDTH_DEFAULT = 32;
  localparam int unsigned LINE_WIDTH_DEFAULT = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } arb_req_t;

endpackage

// File: rtl/cache_arbiter_fsm.sv
// Grant FSM for cache_arbiter: state register, grant decision and, when
// ARB_ROUND_ROBIN_EN is defined, the last_grant register used to break ties.
import arbiter_types::*;

module arbiter_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req,
  input  logic       d_req,
  input  logic       pmem_resp,
  output arb_state_t state,
  output logic       grant,
  output arb_req_t   grant_sel
);

  arb_state_t state_q, state_d;
  arb_req_t   sel;

`ifdef ARB_ROUND_ROBIN_EN
  arb_req_t last_grant_q, last_grant_d;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    if (i_req && d_req) sel = (last_grant_q == REQ_D) ? REQ_I : REQ_D;
    else if (d_req)     sel = REQ_D;
    else                sel = REQ_I;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant) last_grant_d = grant_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= REQ_I;
    else     last_grant_q <= last_grant_d;
  end
`else
  always_comb begin
    sel = d_req ? REQ_D : REQ_I;
  end
`endif

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    grant_sel = REQ_I;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          grant     = 1'b1;
          grant_sel = sel;
          state_d   = (sel == REQ_D) ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) state_d = RELEASE;
      end
      // Dead cycle: a request still high right after resp is stale, not new.
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/cache_arbiter.sv
// Shares one cacheline memory port between the I-cache and D-cache miss paths.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking instead of D-over-I priority.
import arbiter_types::*;

module cache_arbiter #(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  arb_state_t state;
  logic       grant;
  arb_req_t   grant_sel;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic                  resp_ok;

  arbiter_fsm u_fsm (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_pmem_read),
    .d_req     (d_pmem_read | d_pmem_write),
    .pmem_resp (pmem_resp),
    .state     (state),
    .grant     (grant),
    .grant_sel (grant_sel)
  );

  // Write wins over read if a D request carries both (cache contract violation).
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    if (grant) begin
      if (grant_sel == REQ_D) begin
        addr_d  = d_pmem_address;
        wdata_d = d_pmem_wdata;
        wr_d    = d_pmem_write;
      end else begin
        addr_d  = i_pmem_address;
        wr_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
    end
  end

  assign pmem_read    = (state == SERVE_I) || ((state == SERVE_D) && !wr_q);
  assign pmem_write   = (state == SERVE_D) && wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  // A transaction abandoned by reset must not complete, even on a coincident resp.
  assign resp_ok      = pmem_resp && !rst;
  assign i_pmem_resp  = (state == SERVE_I) && resp_ok;
  assign d_pmem_resp  = (state == SERVE_D) && resp_ok;
  assign i_pmem_rdata = i_pmem_resp ? pmem_rdata : '0;
  assign d_pmem_rdata = d_pmem_resp ? pmem_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus a randomized run
// against a cycle-level reference model of the arbitration rules.
module tb_cache_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read, d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  // Reference model: who owns the memory port, whether we are in the dead
  // cycle after a completion, and what was captured at grant time.
  int          m_owner;   // 0 none, 1 I, 2 D
  bit          m_dead;
  bit          m_wr;
  bit          m_last_d;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;

  always @(posedge clk) begin
    if (rst) begin
      m_owner <= 0; m_dead <= 1'b0; m_wr <= 1'b0; m_last_d <= 1'b0;
      m_addr <= '0; m_wdata <= '0;
    end else if (m_owner != 0) begin
      if (pmem_resp) begin m_owner <= 0; m_dead <= 1'b1; end
    end else if (m_dead) begin
      m_dead <= 1'b0;
    end else if ((d_pmem_read || d_pmem_write) &&
                 (!i_pmem_read || !RR || !m_last_d)) begin
      m_owner <= 2; m_addr <= d_pmem_address; m_wdata <= d_pmem_wdata;
      m_wr <= d_pmem_write; m_last_d <= 1'b1;
    end else if (i_pmem_read) begin
      m_owner <= 1; m_addr <= i_pmem_address; m_last_d <= 1'b0;
    end
  end

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW/32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle_inputs();
    i_pmem_read = 0; i_pmem_address = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_resp = 0; pmem_rdata = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; pmem_resp = 1; pmem_rdata = rand_line();
    @(negedge clk); #1;
    n_chk++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) $display("FAIL reset_resp_in_rst: got %b want 00", {i_pmem_resp, d_pmem_resp}); else n_pass++;
    @(negedge clk);
    rst = 0; pmem_resp = 0;
    #1;
    n_chk++; if ({pmem_read, pmem_write} !== 2'b00) $display("FAIL reset_strobes: got %b want 00", {pmem_read, pmem_write}); else n_pass++;
    n_chk++; if (pmem_address !== '0) $display("FAIL reset_addr: got %h want 0", pmem_address); else n_pass++;
    n_chk++; if (pmem_wdata !== '0) $display("FAIL reset_wdata: got %h want 0", pmem_wdata); else n_pass++;
    n_chk++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) $display("FAIL reset_resp: got %b want 00", {i_pmem_resp, d_pmem_resp}); else n_pass++;
    n_chk++; if ((i_pmem_rdata | d_pmem_rdata) !== '0) $display("FAIL reset_rdata: got %h want 0", i_pmem_rdata | d_pmem_rdata); else n_pass++;
  endtask

  task automatic test_i_only();
    logic [LW-1:0] aa;
    aa = {(LW/8){8'hAA}};
    @(negedge clk);
    i_pmem_read = 1; i_pmem_address = 32'h0000_1000;
    #1;
    n_chk++; if (pmem_read !== 1'b0) $display("FAIL i_only_no_early_strobe: got %b want 0", pmem_read); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (pmem_read !== 1'b1) $display("FAIL i_only_strobe: got %b want 1", pmem_read); else n_pass++;
    n_chk++; if (pmem_address !== 32'h1000) $display("FAIL i_only_addr: got %h want 1000", pmem_address); else n_pass++;
    repeat (3) @(negedge clk);
    @(negedge clk);
    pmem_resp = 1; pmem_rdata = aa;
    #1;
    n_chk++; if (i_pmem_resp !== 1'b1) $display("FAIL i_only_resp: got %b want 1", i_pmem_resp); else n_pass++;
    n_chk++; if (i_pmem_rdata !== aa) $display("FAIL i_only_rdata: got %h want %h", i_pmem_rdata, aa); else n_pass++;
    n_chk++; if (d_pmem_resp !== 1'b0 || d_pmem_rdata !== '0) $display("FAIL i_only_d_quiet: got resp %b rdata %h want 0", d_pmem_resp, d_pmem_rdata); else n_pass++;
    n_chk++; if (pmem_read !== 1'b1) $display("FAIL i_only_strobe_at_resp: got %b want 1", pmem_read); else n_pass++;
    @(negedge clk);
    pmem_resp = 0; i_pmem_read = 0;
    #1;
    n_chk++; if ({pmem_read, i_pmem_resp} !== 2'b00) $display("FAIL i_only_release: got %b want 00", {pmem_read, i_pmem_resp}); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_simultaneous(input bit d_first, input string tag);
    logic [LW-1:0] w, r0, r1;
    w = rand_line(); r0 = rand_line(); r1 = rand_line();
    @(negedge clk);
    i_pmem_read = 1; i_pmem_address = 32'h1000;
    d_pmem_write = 1; d_pmem_address = 32'h2000; d_pmem_wdata = w;
    #1;
    n_chk++; if ({pmem_read, pmem_write} !== 2'b00) $display("FAIL %s_idle: got %b want 00", tag, {pmem_read, pmem_write}); else n_pass++;
    for (int ph = 0; ph < 2; ph++) begin
      bit is_d;
      is_d = (ph == 0) ? d_first : !d_first;
      if (ph == 1) begin
        @(negedge clk); #1;
        n_chk++; if ({pmem_read, pmem_write} !== 2'b00) $display("FAIL %s_gap: got %b want 00", tag, {pmem_read, pmem_write}); else n_pass++;
      end
      @(negedge clk); #1;
      n_chk++; if ({pmem_read, pmem_write} !== (is_d ? 2'b01 : 2'b10)) $display("FAIL %s_strobe%0d: got %b want %b", tag, ph, {pmem_read, pmem_write}, is_d ? 2'b01 : 2'b10); else n_pass++;
      n_chk++; if (pmem_address !== (is_d ? 32'h2000 : 32'h1000)) $display("FAIL %s_addr%0d: got %h want %h", tag, ph, pmem_address, is_d ? 32'h2000 : 32'h1000); else n_pass++;
      if (is_d) begin
        n_chk++; if (pmem_wdata !== w) $display("FAIL %s_wdata: got %h want %h", tag, pmem_wdata, w); else n_pass++;
      end
      @(negedge clk);
      pmem_resp = 1; pmem_rdata = (ph == 0) ? r0 : r1;
      #1;
      n_chk++; if ({i_pmem_resp, d_pmem_resp} !== (is_d ? 2'b01 : 2'b10)) $display("FAIL %s_resp%0d: got %b want %b", tag, ph, {i_pmem_resp, d_pmem_resp}, is_d ? 2'b01 : 2'b10); else n_pass++;
      n_chk++; if ((is_d ? d_pmem_rdata : i_pmem_rdata) !== pmem_rdata) $display("FAIL %s_rdata%0d: got %h want %h", tag, ph, is_d ? d_pmem_rdata : i_pmem_rdata, pmem_rdata); else n_pass++;
      n_chk++; if ((is_d ? i_pmem_rdata : d_pmem_rdata) !== '0) $display("FAIL %s_other_rdata%0d: got %h want 0", tag, ph, is_d ? i_pmem_rdata : d_pmem_rdata); else n_pass++;
      @(negedge clk);
      pmem_resp = 0;
      if (is_d) d_pmem_write = 0; else i_pmem_read = 0;
      #1;
      n_chk++; if ({pmem_read, pmem_write} !== 2'b00) $display("FAIL %s_release%0d: got %b want 00", tag, ph, {pmem_read, pmem_write}); else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_addr_stability();
    @(negedge clk);
    d_pmem_read = 1; d_pmem_address = 32'h2000;
    @(negedge clk); #1;
    n_chk++; if (pmem_read !== 1'b1 || pmem_address !== 32'h2000) $display("FAIL stab_start: got rd %b addr %h want 1 2000", pmem_read, pmem_address); else n_pass++;
    @(negedge clk);
    d_pmem_address = 32'h3000;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++; if (pmem_address !== 32'h2000) $display("FAIL stab_hold%0d: got %h want 2000", k, pmem_address); else n_pass++;
      @(negedge clk);
    end
    pmem_resp = 1; pmem_rdata = rand_line();
    #1;
    n_chk++; if (pmem_address !== 32'h2000 || d_pmem_resp !== 1'b1) $display("FAIL stab_resp: got addr %h resp %b want 2000 1", pmem_address, d_pmem_resp); else n_pass++;
    @(negedge clk);
    pmem_resp = 0; d_pmem_read = 0;
    @(negedge clk);
  endtask

  task automatic test_stale_request();
    @(negedge clk);
    i_pmem_read = 1; i_pmem_address = 32'h4000;
    @(negedge clk);
    @(negedge clk);
    pmem_resp = 1; pmem_rdata = rand_line();
    #1;
    n_chk++; if (i_pmem_resp !== 1'b1) $display("FAIL stale_resp: got %b want 1", i_pmem_resp); else n_pass++;
    @(negedge clk);
    pmem_resp = 0;
    #1;
    n_chk++; if (pmem_read !== 1'b0) $display("FAIL stale_release: got %b want 0", pmem_read); else n_pass++;
    @(negedge clk);
    i_pmem_read = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_chk++; if ({pmem_read, pmem_write} !== 2'b00) $display("FAIL stale_regrant%0d: got %b want 00", k, {pmem_read, pmem_write}); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    d_pmem_write = 1; d_pmem_address = 32'h5000; d_pmem_wdata = rand_line();
    @(negedge clk); #1;
    n_chk++; if (pmem_write !== 1'b1) $display("FAIL rstmid_strobe: got %b want 1", pmem_write); else n_pass++;
    @(negedge clk);
    rst = 1; pmem_resp = 1; pmem_rdata = rand_line();
    #1;
    n_chk++; if (d_pmem_resp !== 1'b0) $display("FAIL rstmid_no_resp: got %b want 0", d_pmem_resp); else n_pass++;
    @(negedge clk);
    rst = 0; pmem_resp = 0; d_pmem_write = 0;
    #1;
    n_chk++; if ({pmem_read, pmem_write} !== 2'b00) $display("FAIL rstmid_strobes: got %b want 00", {pmem_read, pmem_write}); else n_pass++;
    n_chk++; if (pmem_address !== '0) $display("FAIL rstmid_addr: got %h want 0", pmem_address); else n_pass++;
    // A fresh request one cycle later shows the FSM is back in IDLE.
    i_pmem_read = 1; i_pmem_address = 32'h6000;
    @(negedge clk); #1;
    n_chk++; if (pmem_read !== 1'b1 || pmem_address !== 32'h6000) $display("FAIL rstmid_idle: got rd %b addr %h want 1 6000", pmem_read, pmem_address); else n_pass++;
    @(negedge clk);
    pmem_resp = 1;
    @(negedge clk);
    pmem_resp = 0; i_pmem_read = 0;
    @(negedge clk);
  endtask

  task automatic test_spurious_resp();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      pmem_resp = 1; pmem_rdata = rand_line();
      #1;
      n_chk++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) $display("FAIL spurious_resp%0d: got %b want 00", k, {i_pmem_resp, d_pmem_resp}); else n_pass++;
      n_chk++; if ((i_pmem_rdata | d_pmem_rdata) !== '0) $display("FAIL spurious_rdata%0d: got %h want 0", k, i_pmem_rdata | d_pmem_rdata); else n_pass++;
    end
    @(negedge clk);
    pmem_resp = 0;
  endtask

  task automatic test_random(input int cycles);
    bit i_seen, i_stale, d_seen, d_stale, mem_busy;
    int mem_cnt;
    bit e_rd, e_wr, e_ir, e_dr;
    i_seen = 0; i_stale = 0; d_seen = 0; d_stale = 0; mem_busy = 0; mem_cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      // Memory: answer a live strobe after 0..4 cycles, occasionally glitch resp when idle.
      pmem_resp = 0;
      if ((pmem_read || pmem_write) && !mem_busy) begin mem_busy = 1; mem_cnt = $urandom_range(0, 4); end
      if (mem_busy) begin
        if (mem_cnt == 0) begin pmem_resp = 1; pmem_rdata = rand_line(); mem_busy = 0; end
        else mem_cnt--;
      end else if ($urandom_range(0, 15) == 0) begin
        pmem_resp = 1; pmem_rdata = rand_line();
      end
      // Requesters hold until resp, then drop at once or one cycle late.
      if (i_pmem_read) begin
        if (i_seen) begin
          if (!i_stale && $urandom_range(0, 3) == 0) i_stale = 1;
          else begin i_pmem_read = 0; i_seen = 0; i_stale = 0; end
        end else if ($urandom_range(0, 7) == 0) i_pmem_address = $urandom;
      end else if ($urandom_range(0, 3) == 0) begin
        i_pmem_read = 1; i_pmem_address = $urandom;
      end
      if (d_pmem_read || d_pmem_write) begin
        if (d_seen) begin
          if (!d_stale && $urandom_range(0, 3) == 0) d_stale = 1;
          else begin d_pmem_read = 0; d_pmem_write = 0; d_seen = 0; d_stale = 0; end
        end else if ($urandom_range(0, 7) == 0) begin
          d_pmem_address = $urandom; d_pmem_wdata = rand_line();
        end
      end else if ($urandom_range(0, 3) == 0) begin
        int op;
        op = $urandom_range(0, 9);
        d_pmem_read = (op < 5) || (op == 9); d_pmem_write = (op >= 5);
        d_pmem_address = $urandom; d_pmem_wdata = rand_line();
      end
      rst = ($urandom_range(0, 149) == 0);
      if (rst) begin
        i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0;
        i_seen = 0; i_stale = 0; d_seen = 0; d_stale = 0; mem_busy = 0;
      end
      #1;
      e_rd = (m_owner == 1) || (m_owner == 2 && !m_wr);
      e_wr = (m_owner == 2) && m_wr;
      e_ir = (m_owner == 1) && pmem_resp && !rst;
      e_dr = (m_owner == 2) && pmem_resp && !rst;
      n_chk++; if ({pmem_read, pmem_write} !== {e_rd, e_wr}) $display("FAIL rand_strobes c%0d: got %b want %b", c, {pmem_read, pmem_write}, {e_rd, e_wr}); else n_pass++;
      n_chk++; if (pmem_address !== m_addr) $display("FAIL rand_addr c%0d: got %h want %h", c, pmem_address, m_addr); else n_pass++;
      n_chk++; if (pmem_wdata !== m_wdata) $display("FAIL rand_wdata c%0d: got %h want %h", c, pmem_wdata, m_wdata); else n_pass++;
      n_chk++; if ({i_pmem_resp, d_pmem_resp} !== {e_ir, e_dr}) $display("FAIL rand_resp c%0d: got %b want %b", c, {i_pmem_resp, d_pmem_resp}, {e_ir, e_dr}); else n_pass++;
      n_chk++; if (i_pmem_rdata !== (e_ir ? pmem_rdata : '0)) $display("FAIL rand_i_rdata c%0d: got %h", c, i_pmem_rdata); else n_pass++;
      n_chk++; if (d_pmem_rdata !== (e_dr ? pmem_rdata : '0)) $display("FAIL rand_d_rdata c%0d: got %h", c, d_pmem_rdata); else n_pass++;
      if (e_ir) i_seen = 1;
      if (e_dr) d_seen = 1;
    end
    @(negedge clk);
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_i_only();
    test_simultaneous(1'b1, "simul_fixed");
    test_addr_stability();
    // Last grant was D here, so round-robin hands the tie to I.
    test_simultaneous(!RR, "simul_after_d");
    test_stale_request();
    test_reset_mid_op();
    test_spurious_resp();
    test_random(3000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
